// File: rtl/ysyx_23060077_riscv_fetch_ctrl_if.sv
// rtl/ysyx_23060077_riscv_fetch_ctrl_if.sv - redirect, imem request/response and decode hand-off bundle
interface ysyx_23060077_riscv_fetch_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [INST_WIDTH-1:0] imem_resp_data;
  logic                  imem_resp_err;
  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] id_pc;
  logic [INST_WIDTH-1:0] id_inst;
  logic                  id_fault;

  // master is the fetch controller; slave is memory, EXU and decode together
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data, imem_resp_err,
    output id_valid, id_pc, id_inst, id_fault,
    input  id_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data, imem_resp_err,
    input  id_valid, id_pc, id_inst, id_fault,
    output id_ready
  );
endinterface

// File: rtl/ysyx_23060077_riscv_fetch_ctrl.sv
// rtl/ysyx_23060077_riscv_fetch_ctrl.sv - fetch PC owner with one outstanding imem read and decode buffer
module ysyx_23060077_riscv_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input logic clk,
  input logic rst,
  ysyx_23060077_riscv_fetch_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_kill;
  logic                  r_id_valid;
  logic [DATA_WIDTH-1:0] r_id_pc;
  logic [INST_WIDTH-1:0] r_id_inst;
  logic                  r_id_fault;

  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_pc_seq;

  assign w_target = bus.redirect_pc & ~DATA_WIDTH'(3);
  assign w_pc_seq = r_pc + DATA_WIDTH'(4);

  assign bus.imem_req_valid = (r_state == S_REQ);
  assign bus.imem_req_addr  = r_pc;
  assign bus.id_valid       = r_id_valid;
  assign bus.id_pc          = r_id_pc;
  assign bus.id_inst        = r_id_inst;
  assign bus.id_fault       = r_id_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (bus.redirect_valid) r_pc <= w_target;
        end
        S_REQ: begin
          if (bus.redirect_valid) r_pc <= w_target;
          // a redirect racing the accept leaves a request in flight for the old pc
          if (bus.imem_req_ready) begin
            r_state <= S_WAIT;
            r_kill  <= bus.redirect_valid;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            r_pc <= w_target;
            if (bus.imem_resp_valid) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (bus.imem_resp_valid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_id_valid <= 1'b1;
              r_id_pc    <= r_pc;
              r_id_inst  <= bus.imem_resp_err ? '0 : bus.imem_resp_data;
              r_id_fault <= bus.imem_resp_err;
              r_state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            r_id_valid <= 1'b0;
            r_pc       <= w_target;
            r_state    <= S_REQ;
          end else if (bus.id_ready) begin
            r_id_valid <= 1'b0;
            r_pc       <= w_pc_seq;
            r_state    <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_riscv_fetch_ctrl.sv
// tb/tb_ysyx_23060077_riscv_fetch_ctrl.sv - scoreboard bench with table-driven fetch stream and redirect/reset sequences
module tb_ysyx_23060077_riscv_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic        err;
    int          stall;
    logic [31:0] inst;
    logic        fault;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } id_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060077_riscv_fetch_ctrl_if #(.DATA_WIDTH(32), .INST_WIDTH(32)) bus ();

  ysyx_23060077_riscv_fetch_ctrl #(
    .DATA_WIDTH(32),
    .INST_WIDTH(32),
    .RESET_PC  (32'h8000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_req[$];
  id_exp_t     exp_id[$];

  int          lat       = 1;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] err_addr  = 32'hFFFF_FFFF;

  logic        s_req_valid, s_id_valid, s_id_fault;
  logic [31:0] s_id_pc, s_id_inst;
  logic        req_hs, id_hs;
  int          hs_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // one clock: sample and score at negedge, then drive memory response just after posedge
  task automatic step();
    id_exp_t e;
    @(negedge clk);
    s_req_valid = bus.imem_req_valid;
    s_id_valid  = bus.id_valid;
    s_id_pc     = bus.id_pc;
    s_id_inst   = bus.id_inst;
    s_id_fault  = bus.id_fault;
    req_hs = bus.imem_req_valid && bus.imem_req_ready && !rst;
    id_hs  = bus.id_valid && bus.id_ready && !rst;
    if (req_hs) begin
      if (exp_req.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL req_unexpected: got addr %h expected none", bus.imem_req_addr);
      end else begin
        chk("req_addr", bus.imem_req_addr, exp_req.pop_front());
      end
      pend_cnt  = lat;
      pend_addr = bus.imem_req_addr;
    end
    if (id_hs) begin
      hs_cyc = cyc;
      if (exp_id.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL id_unexpected: got pc %h expected none", bus.id_pc);
      end else begin
        e = exp_id.pop_front();
        chk("id_pc", bus.id_pc, e.pc);
        chk("id_inst", bus.id_inst, e.inst);
        chk("id_fault", 32'(bus.id_fault), 32'(e.fault));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err   = 1'b0;
    bus.imem_resp_data  = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_err   = (pend_addr == err_addr);
        bus.imem_resp_data  = (pend_addr == err_addr) ? 32'hDEAD_BEEF : mem_word(pend_addr);
      end
    end
  endtask

  task automatic wait_req_hs(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (req_hs) got = 1'b1;
    end
    if (!got) fail({name, "_req_timeout"});
  endtask

  // expect one fetch of pc; hold id_ready low for `stall` HOLD cycles, checking stability
  task automatic run_one(input string name, input logic [31:0] pc, input logic [31:0] inst,
                         input logic fault, input int stall, output int done_cyc);
    id_exp_t     e;
    logic        got;
    int          held;
    logic [31:0] h_pc, h_inst;
    logic        h_fault;
    e.pc = pc; e.inst = inst; e.fault = fault;
    exp_req.push_back(pc);
    exp_id.push_back(e);
    bus.id_ready = (stall == 0);
    got = 1'b0; held = 0; done_cyc = -1;
    h_pc = '0; h_inst = '0; h_fault = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (id_hs) begin
        got = 1'b1;
        done_cyc = hs_cyc;
      end else if (s_id_valid) begin
        if (held == 0) begin
          h_pc = s_id_pc; h_inst = s_id_inst; h_fault = s_id_fault;
        end else begin
          chk({name, "_hold_pc"}, s_id_pc, h_pc);
          chk({name, "_hold_inst"}, s_id_inst, h_inst);
          chk({name, "_hold_fault"}, 32'(s_id_fault), 32'(h_fault));
        end
        chk({name, "_hold_no_req"}, 32'(s_req_valid), 32'd0);
        held++;
        if (held >= stall) bus.id_ready = 1'b1;
      end
    end
    if (!got) fail({name, "_id_timeout"});
    if (stall > 0) chk({name, "_stall_cycles"}, 32'(held), 32'(stall));
  endtask

  vec_t tbl[6];
  int   prev_cyc, done_cyc;
  logic got_v;

  initial begin
    tbl[0] = '{pc: 32'h8000_0000, err: 1'b0, stall: 0, inst: 32'h9357_9BDF, fault: 1'b0};
    tbl[1] = '{pc: 32'h8000_0004, err: 1'b0, stall: 5, inst: 32'h9357_9BDB, fault: 1'b0};
    tbl[2] = '{pc: 32'h8000_0008, err: 1'b0, stall: 0, inst: 32'h9357_9BD7, fault: 1'b0};
    tbl[3] = '{pc: 32'h8000_000C, err: 1'b0, stall: 0, inst: 32'h9357_9BD3, fault: 1'b0};
    tbl[4] = '{pc: 32'h8000_0010, err: 1'b1, stall: 0, inst: 32'h0000_0000, fault: 1'b1};
    tbl[5] = '{pc: 32'h8000_0014, err: 1'b0, stall: 0, inst: 32'h9357_9BCB, fault: 1'b0};

    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_resp_err   = 1'b0;
    bus.id_ready        = 1'b0;

    // reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_req_valid", 32'(s_req_valid), 32'd0);
    chk("rst_id_valid", 32'(s_id_valid), 32'd0);
    chk("rst_id_pc", s_id_pc, 32'd0);
    chk("rst_id_inst", s_id_inst, 32'd0);
    chk("rst_id_fault", 32'(s_id_fault), 32'd0);

    rst = 1'b0;
    bus.imem_req_ready = 1'b1;
    lat = 1;
    prev_cyc = cyc;
    step();
    chk("idle_req_valid", 32'(s_req_valid), 32'd0);

    // sequential stream: throughput, stall at 0x80000004, fault at 0x80000010
    for (int i = 0; i < 6; i++) begin
      err_addr = tbl[i].err ? tbl[i].pc : 32'hFFFF_FFFF;
      run_one($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].inst, tbl[i].fault, tbl[i].stall, done_cyc);
      chk($sformatf("tbl%0d_spacing", i), 32'(done_cyc - prev_cyc), 32'(3 + tbl[i].stall));
      prev_cyc = done_cyc;
    end
    bus.imem_req_ready = 1'b0;
    err_addr = 32'hFFFF_FFFF;

    // redirect during WAIT, stale response three cycles later
    exp_req.push_back(32'h8000_0018);
    lat = 3;
    bus.imem_req_ready = 1'b1;
    wait_req_hs("rw");
    lat = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_1002;
    run_one("rw", 32'h8000_1000, 32'h9357_8BDF, 1'b0, 0, done_cyc);
    bus.imem_req_ready = 1'b0;

    // redirect coincident with the response in WAIT
    exp_req.push_back(32'h8000_1004);
    lat = 2;
    bus.imem_req_ready = 1'b1;
    wait_req_hs("rc");
    lat = 1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_2000;
    run_one("rc", 32'h8000_2000, 32'h9357_BBDF, 1'b0, 0, done_cyc);
    bus.imem_req_ready = 1'b0;

    // redirect coincident with id_ready in HOLD
    begin
      id_exp_t e;
      e.pc = 32'h8000_2004; e.inst = 32'h9357_BBDB; e.fault = 1'b0;
      exp_req.push_back(32'h8000_2004);
      exp_id.push_back(e);
    end
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    got_v = 1'b0;
    for (int k = 0; k < 20 && !got_v; k++) begin
      step();
      if (s_id_valid) got_v = 1'b1;
    end
    if (!got_v) fail("rh_hold_timeout");
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_3000;
    step();
    chk("rh_consumed", 32'(id_hs), 32'd1);
    run_one("rh", 32'h8000_3000, 32'h9357_ABDF, 1'b0, 0, done_cyc);
    bus.imem_req_ready = 1'b0;

    // reset while in WAIT, response lands the cycle after reset
    exp_req.push_back(32'h8000_3004);
    lat = 2;
    bus.imem_req_ready = 1'b1;
    wait_req_hs("rr");
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rr_req_valid", 32'(s_req_valid), 32'd0);
    chk("rr_id_valid", 32'(s_id_valid), 32'd0);
    chk("rr_id_pc", s_id_pc, 32'd0);
    chk("rr_id_inst", s_id_inst, 32'd0);
    chk("rr_id_fault", 32'(s_id_fault), 32'd0);
    lat = 1;
    bus.imem_req_ready = 1'b1;
    run_one("rr", 32'h8000_0000, 32'h9357_9BDF, 1'b0, 0, done_cyc);
    bus.imem_req_ready = 1'b0;
    step();
    step();

    chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
    chk("id_queue_empty", 32'(exp_id.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
